// File: rtl/ntt_pkg.sv
// Shared constants for the NTT/INTT sequencer: default sizes, modulus and FSM state codes.
// Purely declarative; no logic.
package ntt_pkg;
    localparam int N_DEF    = 17;
    localparam int LOGN_DEF = 8;
    localparam int unsigned Q = 65537;

    typedef logic [1:0] state_t;

    localparam state_t S_IDLE  = 2'd0;
    localparam state_t S_RUN   = 2'd1;
    localparam state_t S_DRAIN = 2'd2;
    localparam state_t S_DONE  = 2'd3;
endpackage

// File: rtl/ntt_intt_sequencer_if.sv
// Control, coefficient-RAM, twiddle-ROM and PE signals of the sequencer in one bundle.
// master = sequencer side, slave = RAM/ROM/PE/host side.
interface ntt_intt_sequencer_if
    import ntt_pkg::*;
#(
    parameter int N    = N_DEF,
    parameter int LOGN = LOGN_DEF
);
    logic            start;
    logic            inv;
    logic            busy;
    logic            done;
    logic [LOGN-1:0] ram_rd_addr0;
    logic [LOGN-1:0] ram_rd_addr1;
    logic [N-1:0]    ram_rd_data0;
    logic [N-1:0]    ram_rd_data1;
    logic            ram_wr_en;
    logic [LOGN-1:0] ram_wr_addr0;
    logic [LOGN-1:0] ram_wr_addr1;
    logic [N-1:0]    ram_wr_data0;
    logic [N-1:0]    ram_wr_data1;
    logic [LOGN-1:0] tw_addr;
    logic [N-1:0]    tw_data;
    logic            pe_inv;
    logic [N-1:0]    pe_a;
    logic [N-1:0]    pe_b;
    logic [N-1:0]    pe_tf;
    logic [N-1:0]    pe_p0;
    logic [N-1:0]    pe_p1;

    modport master (
        input  start, inv, ram_rd_data0, ram_rd_data1, tw_data, pe_p0, pe_p1,
        output busy, done, ram_rd_addr0, ram_rd_addr1, ram_wr_en,
               ram_wr_addr0, ram_wr_addr1, ram_wr_data0, ram_wr_data1,
               tw_addr, pe_inv, pe_a, pe_b, pe_tf
    );

    modport slave (
        output start, inv, ram_rd_data0, ram_rd_data1, tw_data, pe_p0, pe_p1,
        input  busy, done, ram_rd_addr0, ram_rd_addr1, ram_wr_en,
               ram_wr_addr0, ram_wr_addr1, ram_wr_data0, ram_wr_data1,
               tw_addr, pe_inv, pe_a, pe_b, pe_tf
    );
endinterface

// File: rtl/ntt_addr_gen.sv
// Combinational butterfly address generator: (stage, k, inv) -> operand indices i0/i1 and twiddle index.
// Zero latency; no flow control.
module ntt_addr_gen #(
    parameter int LOGN = 8,
    parameter int SW   = $clog2(LOGN + 1)
) (
    input  logic [SW-1:0]   i_stage,
    input  logic [LOGN-1:0] i_k,
    input  logic            i_inv,
    output logic [LOGN-1:0] o_i0,
    output logic [LOGN-1:0] o_i1,
    output logic [LOGN-1:0] o_tw
);
    logic [SW-1:0]   w_lgm;
    logic [SW-1:0]   w_twsh;
    logic [LOGN-1:0] w_m;
    logic [LOGN-1:0] w_g;
    logic [LOGN-1:0] w_j;

    // Half-span m = 1<<lgm shrinks per stage going forward and grows going inverse.
    // The twiddle base exponent is the complement of lgm in both directions.
    always_comb begin
        w_lgm  = i_inv ? i_stage : (SW'(LOGN - 1) - i_stage);
        w_twsh = SW'(LOGN - 1) - w_lgm;
        w_m    = LOGN'(1) << w_lgm;
        w_g    = i_k >> w_lgm;
        w_j    = i_k & (w_m - LOGN'(1));
        o_i0   = (w_g << (w_lgm + SW'(1))) + w_j;
        o_i1   = o_i0 + w_m;
        o_tw   = (LOGN'(1) << w_twsh) + w_g;
    end
endmodule

// File: rtl/ntt_intt_sequencer.sv
// Iterative in-place NTT/INTT controller: one butterfly per RUN cycle, 2-cycle drain between stages.
// Reads issue at c, PE at c+1, write-back at c+2; no backpressure, start ignored while busy.
module ntt_intt_sequencer
    import ntt_pkg::*;
#(
    parameter int N    = N_DEF,
    parameter int LOGN = LOGN_DEF
) (
    input logic                  clk,
    input logic                  rst_n,
    ntt_intt_sequencer_if.master bus
);
    localparam int AW    = LOGN;
    localparam int SW    = $clog2(LOGN + 1);
    localparam int KLAST = (1 << LOGN) / 2 - 1;

    state_t          r_state;
    logic [SW-1:0]   r_stage;
    logic [AW-1:0]   r_k;
    logic            r_drain;
    logic            r_inv;
    logic [AW-1:0]   r_rd_addr0;
    logic [AW-1:0]   r_rd_addr1;
    logic [AW-1:0]   r_tw_addr;
    logic            r_v0;
    logic [AW-1:0]   r_d1_i0;
    logic [AW-1:0]   r_d1_i1;
    logic            r_v1;
    logic            r_wr_en;
    logic [AW-1:0]   r_wr_addr0;
    logic [AW-1:0]   r_wr_addr1;
    logic [N-1:0]    r_wr_data0;
    logic [N-1:0]    r_wr_data1;

    logic [AW-1:0]   w_i0;
    logic [AW-1:0]   w_i1;
    logic [AW-1:0]   w_tw;
    logic            w_last_k;
    logic            w_last_stage;

    ntt_addr_gen #(.LOGN(LOGN), .SW(SW)) u_addr_gen (
        .i_stage (r_stage),
        .i_k     (r_k),
        .i_inv   (r_inv),
        .o_i0    (w_i0),
        .o_i1    (w_i1),
        .o_tw    (w_tw)
    );

    assign w_last_k     = (r_k == AW'(KLAST));
    assign w_last_stage = (r_stage == SW'(LOGN - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_stage    <= '0;
            r_k        <= '0;
            r_drain    <= 1'b0;
            r_inv      <= 1'b0;
            r_rd_addr0 <= '0;
            r_rd_addr1 <= '0;
            r_tw_addr  <= '0;
            r_v0       <= 1'b0;
            r_d1_i0    <= '0;
            r_d1_i1    <= '0;
            r_v1       <= 1'b0;
            r_wr_en    <= 1'b0;
            r_wr_addr0 <= '0;
            r_wr_addr1 <= '0;
            r_wr_data0 <= '0;
            r_wr_data1 <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_state <= S_RUN;
                        r_stage <= '0;
                        r_k     <= '0;
                        r_inv   <= bus.inv;
                    end
                end
                S_RUN: begin
                    if (w_last_k) begin
                        r_state <= S_DRAIN;
                        r_k     <= '0;
                        r_drain <= 1'b0;
                    end else begin
                        r_k <= r_k + AW'(1);
                    end
                end
                S_DRAIN: begin
                    r_drain <= 1'b1;
                    if (r_drain) begin
                        if (w_last_stage) begin
                            r_state <= S_DONE;
                        end else begin
                            r_state <= S_RUN;
                            r_stage <= r_stage + SW'(1);
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase

            // Read addresses double as the first tap of the write-address delay line.
            r_v0 <= (r_state == S_RUN);
            if (r_state == S_RUN) begin
                r_rd_addr0 <= w_i0;
                r_rd_addr1 <= w_i1;
                r_tw_addr  <= w_tw;
            end
            r_v1    <= r_v0;
            r_d1_i0 <= r_rd_addr0;
            r_d1_i1 <= r_rd_addr1;
            r_wr_en <= r_v1;
            if (r_v1) begin
                r_wr_addr0 <= r_d1_i0;
                r_wr_addr1 <= r_d1_i1;
                r_wr_data0 <= bus.pe_p0;
                r_wr_data1 <= bus.pe_p1;
            end
        end
    end

    assign bus.busy         = (r_state != S_IDLE);
    assign bus.done         = (r_state == S_DONE);
    assign bus.ram_rd_addr0 = r_rd_addr0;
    assign bus.ram_rd_addr1 = r_rd_addr1;
    assign bus.tw_addr      = r_tw_addr;
    assign bus.ram_wr_en    = r_wr_en;
    assign bus.ram_wr_addr0 = r_wr_addr0;
    assign bus.ram_wr_addr1 = r_wr_addr1;
    assign bus.ram_wr_data0 = r_wr_data0;
    assign bus.ram_wr_data1 = r_wr_data1;
    assign bus.pe_inv       = r_inv;
    assign bus.pe_a         = bus.ram_rd_data0;
    assign bus.pe_b         = bus.ram_rd_data1;
    assign bus.pe_tf        = bus.tw_data;
endmodule
